// File: rtl/nonce_tx_scheduler_if.sv
// -----------------------------------------------------------------------------
// nonce_tx_scheduler_if
//
// Handshake between the nonce scheduler and the shared serial transmitter.
//   serial_send  : one-cycle send request          (scheduler  -> transmitter)
//   golden_nonce : word to send, held stable from
//                  send until busy falls           (scheduler  -> transmitter)
//   serial_busy  : transmitter is shifting a frame (transmitter -> scheduler)
//
// Modports: master = scheduler side, slave = transmitter side.
// -----------------------------------------------------------------------------
interface nonce_tx_scheduler_if;
    logic        serial_send;
    logic [31:0] golden_nonce;
    logic        serial_busy;

    modport master (output serial_send, output golden_nonce, input serial_busy);
    modport slave  (input serial_send, input golden_nonce, output serial_busy);
endinterface

// File: rtl/nonce_tx_scheduler.sv
// -----------------------------------------------------------------------------
// nonce_tx_scheduler
//
// Collects golden-nonce results from SLAVES sources, queues them round-robin
// into a FIFO_DEPTH-entry FIFO and feeds them one at a time to the shared
// serial transmitter through a send/busy handshake.
//
// Ports:
//   uart_clk      in   single clock
//   reset         in   synchronous, active-high reset
//   new_nonces    in   [SLAVES]      per-slave one-cycle result strobe
//   slave_nonces  in   [SLAVES*32]   result words, slave i in [i*32 +: 32]
//   work_flush    in   one-cycle pulse on new work, discards queued results
//   tx            if   master side of nonce_tx_scheduler_if
//                      (serial_send / golden_nonce out, serial_busy in)
//   fifo_level    out  [$clog2(FIFO_DEPTH)+1]  FIFO occupancy
//   drop_count    out  [8]           saturating count of overwritten results
//
// Build option:
//   NONCE_DUP_FILTER_EN  when defined, a popped word equal to the last
//                        transmitted word is discarded without a send.
// -----------------------------------------------------------------------------
module nonce_tx_scheduler #(
    parameter int SLAVES     = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        uart_clk,
    input  logic                        reset,
    input  logic [SLAVES-1:0]           new_nonces,
    input  logic [SLAVES*32-1:0]        slave_nonces,
    input  logic                        work_flush,
    nonce_tx_scheduler_if.master        tx,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [7:0]                  drop_count
);

    localparam int          PW       = $clog2(FIFO_DEPTH);
    localparam int          SW       = (SLAVES > 1) ? $clog2(SLAVES) : 1;
    localparam logic [PW:0] FULL_LVL = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_t;

    // Capture / arbitration state
    logic [SLAVES-1:0] pend_q;
    logic [31:0]       hold_q [SLAVES];
    logic [SW-1:0]     rr_q;
    logic [7:0]        drop_q, drop_d;

    // FIFO state
    logic [31:0]       fifo_mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PW:0]       count_q;

    // Transmit FSM state
    state_t            state_q;
    logic [1:0]        tmo_q;
    logic              send_q;
    logic [31:0]       golden_q;

    // Combinational helpers
    logic              sel_valid;
    logic [SW-1:0]     sel_idx, next_rr;
    int                cand;
    logic [SLAVES-1:0] drain, drop_vec;
    int                drop_sum;
    logic              fifo_full, pop_fire, push_fire, dup_hit;
    logic [31:0]       head;

    assign head      = fifo_mem_q[rd_ptr_q];
    assign fifo_full = (count_q == FULL_LVL);
    // A flush empties the FIFO, so the idle FSM does not pop in that cycle.
    assign pop_fire  = (state_q == IDLE) && (count_q != '0) && !tx.serial_busy && !work_flush;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_fire = sel_valid && (!fifo_full || pop_fire);
    assign next_rr   = (int'(sel_idx) == SLAVES - 1) ? '0 : sel_idx + 1'b1;

    // Round-robin pick: first pending slave at or after rr_q.
    // NOTE: every variable driven here gets a default before the loop, so no latch is inferred.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int k = 0; k < SLAVES; k++) begin
            cand = (int'(rr_q) + k) % SLAVES;
            if (!sel_valid && pend_q[SW'(cand)]) begin
                sel_valid = 1'b1;
                sel_idx   = SW'(cand);
            end
        end
    end

    // Drain / drop decode. A strobe on the slave being drained this cycle
    // replaces a value that is already on its way into the FIFO: not a drop.
    always_comb begin
        drain    = '0;
        drop_vec = '0;
        for (int i = 0; i < SLAVES; i++) begin
            drain[i]    = push_fire && (sel_idx == SW'(i));
            drop_vec[i] = new_nonces[i] && pend_q[i] && !drain[i] && !work_flush;
        end
        drop_sum = int'(drop_q) + $countones(drop_vec);
        drop_d   = (drop_sum > 255) ? 8'hff : 8'(drop_sum);
    end

    // Pending flags, round-robin pointer and drop counter.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge uart_clk) begin
        if (reset) begin
            pend_q <= '0;
            rr_q   <= '0;
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
            // rr is left alone by a flush so fairness carries across work units.
            if (push_fire && !work_flush) rr_q <= next_rr;
            for (int i = 0; i < SLAVES; i++) begin
                if (work_flush)         pend_q[i] <= 1'b0;
                else if (new_nonces[i]) pend_q[i] <= 1'b1;
                else if (drain[i])      pend_q[i] <= 1'b0;
            end
        end
    end

    // Data storage: hold registers and FIFO cells.
    // NOTE: storage arrays carry no reset; their validity is tracked by pend_q and count_q.
    always_ff @(posedge uart_clk) begin
        for (int i = 0; i < SLAVES; i++) begin
            if (new_nonces[i] && !work_flush) hold_q[i] <= slave_nonces[i*32 +: 32];
        end
        // hold_q still holds the pre-edge value, so a same-cycle capture
        // on the drained slave pushes the old word and keeps the new one.
        if (push_fire && !work_flush) fifo_mem_q[wr_ptr_q] <= hold_q[sel_idx];
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge uart_clk) begin
        if (reset || work_flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_fire) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_fire)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + {{PW{1'b0}}, push_fire} - {{PW{1'b0}}, pop_fire};
        end
    end

`ifdef NONCE_DUP_FILTER_EN
    // Last word actually handed to the transmitter; all-ones means "none yet".
    logic [31:0] last_q;

    always_ff @(posedge uart_clk) begin
        if (reset || work_flush)   last_q <= '1;
        else if (pop_fire && !dup_hit) last_q <= head;
    end

    assign dup_hit = (head == last_q);
`else
    assign dup_hit = 1'b0;
`endif

    // Transmit sequencer. golden_q only loads on IDLE->SEND so the word stays
    // stable for the whole frame; a popped duplicate is simply dropped.
    always_ff @(posedge uart_clk) begin
        if (reset) begin
            state_q  <= IDLE;
            tmo_q    <= '0;
            send_q   <= 1'b0;
            golden_q <= '0;
        end else begin
            send_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pop_fire && !dup_hit) begin
                        golden_q <= head;
                        send_q   <= 1'b1;
                        state_q  <= SEND;
                    end
                end
                SEND: begin
                    tmo_q   <= '0;
                    state_q <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // Four cycles without busy: treat the word as sent.
                    if (tx.serial_busy)      state_q <= WAIT_DONE;
                    else if (tmo_q == 2'd3)  state_q <= IDLE;
                    else                     tmo_q   <= tmo_q + 2'd1;
                end
                WAIT_DONE: begin
                    if (!tx.serial_busy) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx.serial_send  = send_q;
    assign tx.golden_nonce = golden_q;
    assign fifo_level      = count_q;
    assign drop_count      = drop_q;

endmodule

// File: doc/nonce_tx_scheduler.md
# nonce_tx_scheduler

Arbiter and scheduler for the single shared serial transmitter in the miner hub. It captures golden-nonce results from every slave (local hashcores and external slave ports). It queues them round-robin into a small FIFO and sequences the transmitter through a send/busy handshake. Results are never lost while buffering is available; overflows are counted. It sits between the slave result buses and `serial_transmit`.

## Interface
Parameters:
- `SLAVES`, 3, number of result sources (1..16).
- `FIFO_DEPTH`, 4, result FIFO entries; power of two, 2..16.

Ports:
- `uart_clk`  in  1  single clock for the whole block.
- `reset`  in  1  synchronous, active-high reset.
- `new_nonces`  in  SLAVES  per-slave one-cycle result strobe.
- `slave_nonces`  in  SLAVES*32  result words; slave i is in bits [i*32+31:i*32]; valid when its strobe is high.
- `work_flush`  in  1  one-cycle pulse on new work (rx_done); discards queued results.
- `serial_busy`  in  1  transmitter busy.
- `serial_send`  out  1  one-cycle send request to the transmitter.
- `golden_nonce`  out  32  word to transmit; held stable from send until busy falls.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `drop_count`  out  8  saturating count of discarded results.

## Operation
- Capture: each slave has a pending flag and a 32-bit hold register. When a strobe is high, the hold register is loaded and the flag is set. If the flag was already set and the entry is not being drained that cycle, the old value is overwritten and `drop_count` is incremented.
- Arbitration: a round-robin pointer `rr` selects the first pending slave at or after `rr`. It selects at most one slave per cycle, and only when the FIFO is not full. The selected slave's hold value is pushed into the FIFO and its flag is cleared. `rr` then moves to selected+1, modulo SLAVES.
- Capture and drain on the same slave in the same cycle: the old value is pushed, the new value is latched, and the flag stays set. This is not a drop.
- FIFO full: pending flags hold. New strobes on already-pending slaves count as drops.
- Transmit FSM, with states IDLE, SEND, WAIT_BUSY and WAIT_DONE:
  - IDLE: if the FIFO is non-empty and `serial_busy`=0, pop the FIFO head into `golden_nonce` and go to SEND.
  - SEND: `serial_send`=1 for exactly one cycle, then go to WAIT_BUSY.
  - WAIT_BUSY: on `serial_busy`=1 go to WAIT_DONE. If 4 cycles pass without busy, return to IDLE; the word counts as sent.
  - WAIT_DONE: on `serial_busy`=0 go to IDLE.
- `work_flush`: clears the FIFO and all pending flags. Strobes in the same cycle are also discarded. The in-flight transmission (SEND, WAIT_BUSY or WAIT_DONE) completes unchanged. Flushed entries do not count as drops. `rr` is preserved.
- `drop_count` saturates at 255 and is cleared only by `reset`.
- Push and pop in the same cycle: allowed. A full FIFO may push when it also pops.

## Timing
- Reset values: `serial_send`=0, `golden_nonce`=0, `fifo_level`=0, `drop_count`=0. Reset also sets FSM=IDLE, `rr`=0 and all flags clear.
- `reset` overrides `work_flush` and all strobes. Reset mid-transmission abandons the word; the transmitter handles its own frame.
- Latency with the FIFO empty and the transmitter idle:
  - Strobe at cycle t: pending set at edge t+1.
  - FIFO push at edge t+2.
  - Pop and FSM→SEND at edge t+3.
  - `serial_send` high during cycle t+3.
  - Total: 3 cycles from strobe to send.
- Maximum throughput: one FIFO push per cycle and one transmission per serial frame.
- `golden_nonce` changes only on the IDLE→SEND transition.

## Configuration
- `NONCE_DUP_FILTER_EN` defined:
  - When IDLE pops a word equal to the last transmitted word, the word is discarded with no send. The FSM stays IDLE, and `drop_count` is not incremented.
  - The last-word register resets to 32'hffffffff and is also set to 32'hffffffff on `work_flush`.
- `NONCE_DUP_FILTER_EN` undefined: every popped word is transmitted.

## Test plan
- Single result: SLAVES=3; strobe slave 1 with 32'h0000_1234 at cycle 10, `serial_busy` pulses high 2 cycles after send for 20 cycles → `serial_send` exactly once at cycle 13, `golden_nonce`=32'h0000_1234, `fifo_level` returns to 0.
- Simultaneous strobes: all 3 slaves strobe in the same cycle with 32'hA0/32'hB1/32'hC2, `rr`=0 → transmit order A0, B1, C2, then `rr`=0, `drop_count`=0.
- Overflow: FIFO_DEPTH=4 with `serial_busy` held 1; strobe slave 0 eight times on consecutive cycles → `fifo_level`=4, 1 value pending, `drop_count`=3. After busy drops, the first 4 values are sent, then the pending value.
- Flush mid-send: 3 words queued, first in WAIT_DONE, `work_flush` pulsed → first word completes, no further `serial_send`, `fifo_level`=0.
- No busy response: `serial_busy` tied 0 with 2 words queued → each sends, times out 4 cycles later, next sends; 2 sends total.
- Dup filter (`NONCE_DUP_FILTER_EN`): slave 0 then slave 2 both report 32'h5555_0001 → one send. Without the macro → two sends.
